// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch request/response, load/store request/response
// and memory-port signals; slave = arbiter side, master = requesters + memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  localparam int SW = DATA_W / 8;

  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [DATA_W-1:0] d_wdata;
  logic [SW-1:0]     d_wstrb;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [SW-1:0]     mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req_valid,
    input  if_addr,
    output if_req_ready,
    output if_rsp_valid,
    output if_rsp_data,
    input  d_req_valid,
    input  d_addr,
    input  d_we,
    input  d_wdata,
    input  d_wstrb,
    output d_req_ready,
    output d_rsp_valid,
    output d_rsp_data,
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_rdata
  );

  modport master (
    output if_req_valid,
    output if_addr,
    input  if_req_ready,
    input  if_rsp_valid,
    input  if_rsp_data,
    output d_req_valid,
    output d_addr,
    output d_we,
    output d_wdata,
    output d_wstrb,
    input  d_req_ready,
    input  d_rsp_valid,
    input  d_rsp_data,
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store.
// Ports: clk, rst (sync, active-low), bus (slave modport of
// mem_port_arbiter_if: fetch req/rsp, data req/rsp, memory port).
// Data wins conflicts; fetch is forced through after STARVE_MAX denials.
// Read data returns one cycle after the grant, routed by an owner register.
// Optional MEMARB_STATS_EN adds stat_if_grants/stat_d_grants/stat_conflicts.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
`ifdef MEMARB_STATS_EN
  ,
  output logic [31:0] stat_if_grants,
  output logic [31:0] stat_d_grants,
  output logic [31:0] stat_conflicts
`endif
);

  localparam logic [7:0] SMAX = 8'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_IF,
    OWN_D
  } own_e;

  own_e       own_q;
  own_e       own_d;
  logic       wr_q;
  logic [7:0] starve_cnt;
  logic       gnt_if;
  logic       gnt_d;
  logic       both;

  assign both = bus.if_req_valid
             && bus.d_req_valid;

  // Fetch wins when uncontested or once
  // it has been denied STARVE_MAX times.
  assign gnt_if = rst
               && bus.if_req_valid
               && (!bus.d_req_valid
                   || starve_cnt == SMAX);
  assign gnt_d  = rst
               && bus.d_req_valid
               && !gnt_if;

  assign bus.if_req_ready = gnt_if;
  assign bus.d_req_ready  = gnt_d;

  always_comb begin
    bus.mem_en    = gnt_if | gnt_d;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    unique case (1'b1)
      gnt_d: begin
        bus.mem_we    = bus.d_we;
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
        bus.mem_wstrb = bus.d_wstrb;
      end
      gnt_if: begin
        bus.mem_addr  = bus.if_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!bus.if_req_valid
                 || gnt_if) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SMAX) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      own_q <= OWN_IDLE;
      wr_q  <= 1'b0;
    end else begin
      own_q <= own_d;
      wr_q  <= gnt_d && bus.d_we;
    end
  end

  always_comb begin
    own_d = OWN_IDLE;
    unique case (1'b1)
      gnt_if:  own_d = OWN_IF;
      gnt_d:   own_d = OWN_D;
      default: ;
    endcase
  end

  always_comb begin
    bus.if_rsp_valid = 1'b0;
    bus.if_rsp_data  = '0;
    bus.d_rsp_valid  = 1'b0;
    bus.d_rsp_data   = '0;
    unique case (own_q)
      OWN_IF: begin
        bus.if_rsp_valid = 1'b1;
        bus.if_rsp_data  = bus.mem_rdata;
      end
      OWN_D: begin
        bus.d_rsp_valid  = 1'b1;
        // stores are acknowledged with 0
        bus.d_rsp_data   = wr_q ? '0
                         : bus.mem_rdata;
      end
      default: ;
    endcase
  end

`ifdef MEMARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_if_grants <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      if (gnt_if)
        stat_if_grants <= stat_if_grants + 32'd1;
      if (gnt_d)
        stat_d_grants  <= stat_d_grants + 32'd1;
      if (both)
        stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`else
  logic unused_both;
  assign unused_both = both;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random fetch/load/store traffic against a
// queue-based reference; monitor pops expected responses.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;
  localparam int NCYC = 3000;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   started = 0;

  mem_port_arbiter_if #(
    .ADDR_W(16),
    .DATA_W(32)
  ) bus ();

`ifdef MEMARB_STATS_EN
  logic [31:0] st_if;
  logic [31:0] st_d;
  logic [31:0] st_c;
`endif

  mem_port_arbiter #(
    .ADDR_W(16),
    .DATA_W(32),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MEMARB_STATS_EN
    ,
    .stat_if_grants(st_if),
    .stat_d_grants(st_d),
    .stat_conflicts(st_c)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t if_q[$];
  exp_t d_q[$];

  logic [31:0] dev_mem[int];
  logic [31:0] ref_mem[int];

  function automatic logic [31:0] init_word(int a);
    return 32'hA5000000 ^ (32'(a) * 32'h00010101);
  endfunction

  function automatic logic [31:0] ref_read(int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  ws
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (ws[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(
    input string      nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cyc %0d)", nm, cyc);
  endtask

  // memory device behind the port: one-cycle read latency,
  // garbage on rdata whenever no read was issued
  always @(posedge clk) begin
    int a;
    logic [31:0] old;
    a = int'(bus.mem_addr);
    old = dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1)
      dev_mem[a] = merge(old, bus.mem_wdata, bus.mem_wstrb);
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b0)
      bus.mem_rdata <= old;
    else
      bus.mem_rdata <= $urandom;
  end

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (bus.if_rsp_valid === 1'b1) begin
        if (if_q.size() == 0) flag("if_rsp_spurious");
        else begin
          e = if_q.pop_front();
          chk("if_rsp_cycle", 64'(cyc), 64'(e.due));
          chk("if_rsp_data", bus.if_rsp_data, e.data);
        end
      end else begin
        chk("if_rsp_idle", {bus.if_rsp_valid, bus.if_rsp_data}, 0);
        if (if_q.size() > 0 && if_q[0].due <= cyc) begin
          flag("if_rsp_missing");
          void'(if_q.pop_front());
        end
      end
      if (bus.d_rsp_valid === 1'b1) begin
        if (d_q.size() == 0) flag("d_rsp_spurious");
        else begin
          e = d_q.pop_front();
          chk("d_rsp_cycle", 64'(cyc), 64'(e.due));
          chk("d_rsp_data", bus.d_rsp_data, e.data);
        end
      end else begin
        chk("d_rsp_idle", {bus.d_rsp_valid, bus.d_rsp_data}, 0);
        if (d_q.size() > 0 && d_q[0].due <= cyc) begin
          flag("d_rsp_missing");
          void'(d_q.pop_front());
        end
      end
    end
  end

  bit          if_pend;
  bit          d_pend;
  logic [15:0] if_a;
  logic [15:0] d_a;
  logic        d_w;
  logic [31:0] d_wd;
  logic [3:0]  d_ws;
  int          if_wait;
  bit          r_rst;
  bit          e_if;
  bit          e_d;
  int          m_if;
  int          m_d;
  int          m_c;

  task automatic drive();
    bus.if_req_valid = if_pend;
    bus.if_addr      = if_a;
    bus.d_req_valid  = d_pend;
    bus.d_addr       = d_a;
    bus.d_we         = d_w;
    bus.d_wdata      = d_wd;
    bus.d_wstrb      = d_ws;
  endtask

  initial begin
    int p_if;
    int p_d;
    rst = 1'b0;
    if_pend = 1; d_pend = 1;
    if_a = 16'h0010; d_a = 16'h0200;
    d_w = 0; d_wd = 0; d_ws = 0;
    drive();
    if_wait = 0;
    m_if = 0; m_d = 0; m_c = 0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_if_ready", bus.if_req_ready, 0);
    chk("rst_d_ready", bus.d_req_ready, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 0);
    chk("rst_if_rsp", {bus.if_rsp_valid, bus.if_rsp_data}, 0);
    chk("rst_d_rsp", {bus.d_rsp_valid, bus.d_rsp_data}, 0);
    started = 1;
    if_pend = 0; d_pend = 0;
    @(posedge clk); #1;

    for (int c = 0; c < NCYC; c++) begin
      if (c >= 600 && c < 700) begin
        p_if = 100; p_d = 100; r_rst = 1;
      end else begin
        p_if = 55; p_d = 70;
        r_rst = ($urandom_range(0, 49) != 0);
      end
      rst = r_rst;
      if (!if_pend && $urandom_range(0, 99) < p_if) begin
        if_pend = 1;
        if_a = 16'($urandom_range(0, 31));
      end
      if (!d_pend && $urandom_range(0, 99) < p_d) begin
        d_pend = 1;
        d_a  = 16'($urandom_range(0, 31));
        d_w  = 1'($urandom_range(0, 1));
        d_wd = $urandom;
        d_ws = 4'($urandom_range(0, 15));
      end
      drive();
      #2;

      e_if = r_rst && if_pend && (!d_pend || if_wait >= SMAX);
      e_d  = r_rst && d_pend && !e_if;
      chk("if_req_ready", bus.if_req_ready, e_if);
      chk("d_req_ready", bus.d_req_ready, e_d);
      chk("mem_en", bus.mem_en, e_if || e_d);
      if (e_d) begin
        chk("mem_addr_d", bus.mem_addr, d_a);
        chk("mem_we_d", bus.mem_we, d_w);
        if (d_w) begin
          chk("mem_wdata", bus.mem_wdata, d_wd);
          chk("mem_wstrb", bus.mem_wstrb, d_ws);
        end
      end else if (e_if) begin
        chk("mem_addr_if", bus.mem_addr, if_a);
        chk("mem_we_if", bus.mem_we, 0);
      end else begin
        chk("mem_idle", {bus.mem_we, bus.mem_wstrb}, 0);
      end

      if (e_if)
        if_q.push_back('{cyc + 1, ref_read(int'(if_a))});
      if (e_d) begin
        if (d_w) begin
          d_q.push_back('{cyc + 1, 32'h0});
          ref_mem[int'(d_a)] =
            merge(ref_read(int'(d_a)), d_wd, d_ws);
        end else begin
          d_q.push_back('{cyc + 1, ref_read(int'(d_a))});
        end
      end

      if (!r_rst) begin
        m_if = 0; m_d = 0; m_c = 0;
      end else begin
        m_if += int'(e_if);
        m_d  += int'(e_d);
        m_c  += int'(if_pend && d_pend);
      end

      if (!r_rst || !if_pend || e_if) if_wait = 0;
      else if_wait++;
      if (e_if) if_pend = 0;
      if (e_d)  d_pend = 0;

      @(posedge clk); #1;
    end

    rst = 1'b1;
    if_pend = 0; d_pend = 0;
    drive();
    repeat (3) @(posedge clk);
    #3;
    chk("if_q_drained", 64'(if_q.size()), 0);
    chk("d_q_drained", 64'(d_q.size()), 0);
`ifdef MEMARB_STATS_EN
    chk("stat_if_grants", st_if, 32'(m_if));
    chk("stat_d_grants", st_d, 32'(m_d));
    chk("stat_conflicts", st_c, 32'(m_c));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter sharing the core's single-port unified memory between the instruction-fetch requester and the load/store requester. One access is issued per cycle. Read data returns one cycle later and is routed to the requester that issued it. Data accesses win by default; a starvation counter guarantees fetch progress. Sits inside `core`, between the fetch/LSU stages and `memory`.

## Interface
Parameters:
- `ADDR_W`, 16: word-address width (memory holds words 0x0000–0xFFFF).
- `DATA_W`, 32: data width; `DATA_W/8` strobe bits.
- `STARVE_MAX`, 4: consecutive denied fetch cycles before fetch is forced to win; legal range 1–255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `if_req_valid` in 1; `if_req_ready` out 1; `if_addr` in ADDR_W: fetch read request.
- `if_rsp_valid` out 1; `if_rsp_data` out DATA_W: fetch read data.
- `d_req_valid` in 1; `d_req_ready` out 1; `d_addr` in ADDR_W; `d_we` in 1; `d_wdata` in DATA_W; `d_wstrb` in DATA_W/8: load/store request.
- `d_rsp_valid` out 1; `d_rsp_data` out DATA_W: load data, or write acknowledge.
- `mem_en`, `mem_we` out 1; `mem_addr` out ADDR_W; `mem_wdata` out DATA_W; `mem_wstrb` out DATA_W/8: memory port.
- `mem_rdata` in DATA_W: memory read data, valid the cycle after `mem_en`.

## Operation
- Request handshake: a request transfers in a cycle with valid && ready. Ready is combinational from this cycle's valids and the starvation counter. A requester holds valid and its payload stable until ready.
- Grant rule, evaluated each cycle:
  - only one valid: it is granted;
  - both valid and `starve_cnt == STARVE_MAX`: fetch is granted;
  - otherwise both valid: data is granted.
- Memory port is combinational from the grant:
  - `mem_en` = any grant;
  - address, write data and strobe come from the winner;
  - `mem_we` = `d_we` on a data grant, 0 on a fetch grant.
  - With no grant: `mem_en=0`, `mem_we=0`, `mem_wstrb=0`.
- Owner register (IDLE/IF/D), loaded each cycle with this cycle's grant:
  - IF: `if_rsp_valid=1`, `if_rsp_data=mem_rdata`.
  - D: `d_rsp_valid=1`; `d_rsp_data` = `mem_rdata` for a read, 0 for a write. The write flag is registered alongside the owner.
  - IDLE: no response.
  - Response data is forced to 0 whenever its valid is low.
- Responses cannot be back-pressured. Requesters must sink them.
- `starve_cnt` (8 bit):
  - increments, saturating at STARVE_MAX, in a cycle with `if_req_valid` && !fetch grant;
  - clears on a fetch grant or when `if_req_valid=0`.
- Addresses are word addresses, passed through unmodified. No wrap or range check.

## Timing
- Reset (`rst=0` at a rising edge) sets: owner=IDLE, `starve_cnt=0`, `if_rsp_valid=0`, `d_rsp_valid=0`, both rsp_data=0.
- `mem_*` outputs and both readies are 0 in every cycle where `rst=0`.
- Reset mid-operation drops the in-flight response: no rsp_valid in the cycle after reset.
- Latency: request accepted at edge N → response valid during cycle N+1 (one cycle).
- Throughput: one access per cycle, back-to-back, with no bubble between owners.
- Simultaneous requests: exactly one ready is high. The loser sees ready=0 and retries the next cycle.
- With data continuously valid and fetch valid, fetch is granted once every STARVE_MAX+1 cycles.

## Configuration
- `MEMARB_STATS_EN` defined adds three outputs, each 32-bit and wrapping:
  - `stat_if_grants`: counts fetch grants;
  - `stat_d_grants`: counts data grants;
  - `stat_conflicts`: counts cycles with both valids high.
  - All three are cleared by reset.
- `MEMARB_STATS_EN` undefined: these ports and registers do not exist. Arbitration behaviour is identical either way.

## Test plan
- Fetch only: `if_addr=0x0010` for 3 consecutive cycles with `mem_rdata` = address+0x100 → `if_rsp_valid` in 3 consecutive cycles, each one cycle after its request, with data 0x0110; `d_rsp_valid` stays 0.
- Conflict: both valid, `d_addr=0x0200` read, `if_addr=0x0004` → cycle 0: `d_req_ready=1`, `if_req_ready=0`, `mem_addr=0x0200`; cycle 1: `d_rsp_valid=1` and fetch is granted.
- Starvation, STARVE_MAX=4: data and fetch both held valid for 10 cycles → fetch granted in cycles 4 and 9, data in the other 8; `starve_cnt` returns to 0 after each fetch grant.
- Store: `d_we=1`, `d_addr=0x0300`, `d_wdata=0xDEADBEEF`, `d_wstrb=4'b0011` → `mem_we=1` with those values the same cycle; next cycle `d_rsp_valid=1`, `d_rsp_data=0`.
- Reset mid-flight: read granted at edge N, `rst=0` at edge N+1 → `d_rsp_valid=0`, all `mem_*` outputs 0, `starve_cnt=0`.
- With `MEMARB_STATS_EN`: the starvation scenario → `stat_if_grants=2`, `stat_d_grants=8`, `stat_conflicts=10`.
